// File: rtl/ssd_scan_driver_12h.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// ssd_scan_driver_12h
//
// Display stage for the 12-hour BCD time counter. Takes the six BCD digits and
// the AM/PM flag and drives a 4-digit multiplexed common-anode 7-segment
// display. A debounced push button toggles between two pages:
//   page 0 : HH.MM  (dot after hours, dot on the rightmost digit when PM)
//   page 1 : MM.SS  (dot after minutes)
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (>= 2)
//   DB_LEN    consecutive equal scan-tick samples that move the debounced
//             button level (>= 2)
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   value0_12h   seconds units (BCD)
//   value1_12h   seconds tens
//   value2_12h   minutes units
//   value3_12h   minutes tens
//   value4_12h   hours units
//   value5_12h   hours tens
//   ampm         1 = AM, 0 = PM
//   page_btn     raw asynchronous push button, 1 = pressed
//   ssd_ctl      digit enables, active low, one-hot, bit0 = rightmost digit
//   ssd_out      {a,b,c,d,e,f,g,dp}, active low
//   page         current page (0 = HH.MM, 1 = MM.SS)
// -----------------------------------------------------------------------------
module ssd_scan_driver_12h #(
  parameter int SCAN_DIV = 100000,
  parameter int DB_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value0_12h,
  input  logic [3:0] value1_12h,
  input  logic [3:0] value2_12h,
  input  logic [3:0] value3_12h,
  input  logic [3:0] value4_12h,
  input  logic [3:0] value5_12h,
  input  logic       ampm,
  input  logic       page_btn,
  output logic [3:0] ssd_ctl,
  output logic [7:0] ssd_out,
  output logic       page
);

  localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------------
  // Segment decode (abcdefg, active low). Anything outside 0..9 shows a dash so
  // a corrupted counter is visible rather than silently mis-displayed.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111110;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Scan prescaler: one-cycle tick at the end of every digit slot.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] prescale;
  logic             tick;

  assign tick = (prescale == CNT_MAX);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values of the others, regardless of the
  // order in which the simulator evaluates the blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
    end else if (tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + CNT_W'(1);
    end
  end

  // Digit slot index; free-running, a page change never restarts the scan.
  logic [1:0] scan_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx <= 2'd0;
    end else if (tick) begin
      scan_idx <= scan_idx + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Page button: 2-FF synchroniser, then a DB_LEN-deep shift register sampled
  // once per scan tick. The debounced level only moves when the whole window
  // agrees; the page flips on its rising edge. Because the window only moves
  // on a tick, the debounced edge always coincides with a scan tick.
  // ---------------------------------------------------------------------------
  logic              btn_meta;
  logic              btn_sync;
  logic [DB_LEN-1:0] db_shift;
  logic [DB_LEN-1:0] db_shift_next;
  logic              db_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= page_btn;
      btn_sync <= btn_meta;
    end
  end

  assign db_shift_next = {db_shift[DB_LEN-2:0], btn_sync};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_shift <= '0;
      db_level <= 1'b0;
      page     <= 1'b0;
    end else if (tick) begin
      db_shift <= db_shift_next;
      if (&db_shift_next) begin
        db_level <= 1'b1;
        // Toggle only on the 0->1 transition; a held button keeps the window
        // all-ones but the level is already 1, so no repeat toggles.
        if (!db_level) begin
          page <= ~page;
        end
      end else if (~|db_shift_next) begin
        db_level <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection for the current slot and page. Inputs are used live so a
  // counter rollover reaches the display one cycle later.
  // ---------------------------------------------------------------------------
  logic [3:0] digit;
  logic       dp_n;
  logic       blank;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    digit = 4'd0;
    case (scan_idx)
      2'd0: digit = page ? value0_12h : value2_12h;
      2'd1: digit = page ? value1_12h : value3_12h;
      2'd2: digit = page ? value2_12h : value4_12h;
      2'd3: digit = page ? value3_12h : value5_12h;
      default: digit = 4'd0;
    endcase
  end

  always_comb begin
    dp_n = 1'b1;
    // Separator dot after the left digit pair on both pages.
    if (scan_idx == 2'd2) begin
      dp_n = 1'b0;
    end
    // PM indicator on the rightmost digit of the HH.MM page.
    if (!page && (scan_idx == 2'd0) && !ampm) begin
      dp_n = 1'b0;
    end
  end

  // Leading-zero suppression of the hours tens digit ("1:05" not "01:05").
  assign blank = !page && (scan_idx == 2'd3) && (value5_12h == 4'd0);

  // ---------------------------------------------------------------------------
  // Registered display outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ssd_ctl <= 4'b1111;
      ssd_out <= 8'hFF;
    end else begin
      ssd_ctl <= ~(4'b0001 << scan_idx);
      ssd_out <= blank ? 8'hFF : {seg_decode(digit), dp_n};
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver_12h.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_ssd_scan_driver_12h
//
// Self-checking bench for ssd_scan_driver_12h (SCAN_DIV=4, DB_LEN=4). A
// behavioural model predicts ssd_ctl/ssd_out/page every cycle; a compare
// process checks the DUT on every falling edge. Directed scenarios also pin
// hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_ssd_scan_driver_12h;

  localparam int SCAN_DIV = 4;
  localparam int DB_LEN   = 4;

  localparam logic [6:0] SEG [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] v [6];
  logic       ampm = 1'b1;
  logic       page_btn = 1'b0;
  logic [3:0] ssd_ctl;
  logic [7:0] ssd_out;
  logic       page;

  int vectors = 0;
  int miscompares = 0;

  ssd_scan_driver_12h #(
    .SCAN_DIV (SCAN_DIV),
    .DB_LEN   (DB_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value0_12h (v[0]),
    .value1_12h (v[1]),
    .value2_12h (v[2]),
    .value3_12h (v[3]),
    .value4_12h (v[4]),
    .value5_12h (v[5]),
    .ampm       (ampm),
    .page_btn   (page_btn),
    .ssd_ctl    (ssd_ctl),
    .ssd_out    (ssd_out),
    .page       (page)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int         m_cnt;
  int         m_idx;
  bit         m_page;
  bit         m_db;
  bit         m_s1, m_s2;
  bit         m_samples[$];
  logic [3:0] exp_ctl  = 4'hF;
  logic [7:0] exp_out  = 8'hFF;
  logic       exp_page = 1'b0;

  // What the display should show for a page/slot given the current inputs.
  function automatic logic [7:0] render(input bit pg, input int idx);
    int         base = pg ? 0 : 2;
    logic [3:0] d    = v[base + idx];
    logic [6:0] seg;
    logic       dp;
    if (!pg && idx == 3 && v[5] == 4'd0) return 8'hFF;
    seg = (d > 4'd9) ? 7'b1111110 : SEG[d];
    dp  = !((idx == 2) || (!pg && idx == 0 && !ampm));
    return {seg, dp};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_page = 0; m_db = 0; m_s1 = 0; m_s2 = 0;
      m_samples = {};
      repeat (DB_LEN) m_samples.push_back(1'b0);
      exp_ctl = 4'hF; exp_out = 8'hFF; exp_page = 1'b0;
    end else begin
      bit tk;
      int ones;
      exp_ctl = ~(4'b0001 << m_idx);
      exp_out = render(m_page, m_idx);
      tk = (m_cnt == SCAN_DIV - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      if (tk) begin
        m_samples.push_back(m_s2);
        void'(m_samples.pop_front());
        ones = 0;
        foreach (m_samples[i]) ones += int'(m_samples[i]);
        if (ones == DB_LEN) begin
          if (!m_db) m_page = !m_page;
          m_db = 1;
        end else if (ones == 0) begin
          m_db = 0;
        end
        m_idx = (m_idx + 1) % 4;
      end
      m_s2 = m_s1;
      m_s1 = page_btn;
      exp_page = m_page;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("ctl", {28'd0, ssd_ctl}, {28'd0, exp_ctl});
    check("out", {24'd0, ssd_out}, {24'd0, exp_out});
    check("page", {31'd0, page}, {31'd0, exp_page});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic ticks(input int n);
    repeat (n * SCAN_DIV) @(negedge clk);
  endtask

  task automatic set_time(input int hh, input int mm, input int ss, input bit am);
    v[5] = 4'(hh / 10); v[4] = 4'(hh % 10);
    v[3] = 4'(mm / 10); v[2] = 4'(mm % 10);
    v[1] = 4'(ss / 10); v[0] = 4'(ss % 10);
    ampm = am;
  endtask

  // Wait (bounded) until the model says slot idx is on display, then pin both
  // the DUT and the model to a literal.
  task automatic check_slot(input string name, input int idx, input logic [7:0] lit);
    logic [3:0] want = ~(4'b0001 << idx);
    int n = 0;
    @(negedge clk);
    while (exp_ctl !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: slot %0d never reached (timeout)", name, idx);
    end else begin
      check({name, "_ctl"}, {28'd0, ssd_ctl}, {28'd0, want});
      check({name, "_out"}, {24'd0, ssd_out}, {24'd0, lit});
      check({name, "_model"}, {24'd0, exp_out}, {24'd0, lit});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] walk [4];
    int n;
    walk = '{8'h09, 8'h49, 8'h9E, 8'h9F};
    set_time(11, 59, 59, 1'b1);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctl", {28'd0, ssd_ctl}, 32'hF);
    check("reset_out", {24'd0, ssd_out}, 32'hFF);
    check("reset_page", {31'd0, page}, 32'd0);

    // 11:59:59 AM page 0: each slot exactly SCAN_DIV cycles, from the first edge.
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        @(negedge clk);
        check("walk_ctl", {28'd0, ssd_ctl}, {28'd0, ~(4'b0001 << k)});
        check("walk_out", {24'd0, ssd_out}, {24'd0, walk[k]});
      end
    end

    // 01:05 PM page 0: blanked leading zero, PM dot.
    set_time(1, 5, 0, 1'b0);
    check_slot("pm_idx3", 3, 8'hFF);
    check_slot("pm_idx2", 2, 8'h9E);
    check_slot("pm_idx1", 1, 8'h03);
    check_slot("pm_idx0", 0, 8'h48);

    // Out-of-range digit shows a dash.
    v[2] = 4'hC; ampm = 1'b1;
    check_slot("dash", 0, 8'hFD);

    // Press for 5 ticks -> page 1; seconds units 9, no PM dot.
    set_time(1, 5, 9, 1'b0);
    page_btn = 1'b1;
    ticks(5);
    check("press1_page", {31'd0, page}, 32'd1);
    check_slot("p1_idx0", 0, 8'h09);
    ticks(20);
    check("hold_page", {31'd0, page}, 32'd1);
    page_btn = 1'b0;
    ticks(6);
    check("release_page", {31'd0, page}, 32'd1);
    page_btn = 1'b1;
    ticks(5);
    check("press2_page", {31'd0, page}, 32'd0);
    page_btn = 1'b0;
    ticks(6);

    // Bounce never fills the window.
    page_btn = 1'b1; ticks(2);
    page_btn = 1'b0; ticks(1);
    page_btn = 1'b1; ticks(2);
    page_btn = 1'b0; ticks(6);
    check("bounce_page", {31'd0, page}, 32'd0);

    // Reset mid-operation on page 1, slot 2.
    page_btn = 1'b1;
    ticks(5);
    n = 0;
    while (!(m_idx == 2 && m_page) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_setup_page", {31'd0, page}, 32'd1);
    #2 rst = 1'b1;
    page_btn = 1'b0;
    #1;
    check("rst_async_ctl", {28'd0, ssd_ctl}, 32'hF);
    check("rst_async_out", {24'd0, ssd_out}, 32'hFF);
    check("rst_async_page", {31'd0, page}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_release_ctl", {28'd0, ssd_ctl}, 32'hE);
    check("rst_release_page", {31'd0, page}, 32'd0);

    // Randomised inputs and button activity, checked every cycle.
    repeat (60) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) v[i] = 4'($urandom_range(0, 15));
      ampm = 1'($urandom_range(0, 1));
      page_btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(24, 40)) @(negedge clk);
      else repeat ($urandom_range(1, 24)) @(negedge clk);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
